// File: rtl/ref_fifo_wr_ptr_ctrl.sv
// Write-side pointer controller for a dual-clock FIFO.
// Holds the binary write pointer, drives the RAM write address and
// publishes a registered Gray copy of the pointer for the read domain.
// The read pointer arrives as Gray, already synchronized into clk. From it
// this block derives full, almost_full, level and overflow.
//
// Ports:
//   clk          write-domain clock
//   rst          synchronous reset, active-high
//   wr_en        producer write request
//   rd_gray_sync read pointer (Gray, ADDR_WIDTH+1 bits), synchronized to clk
//   wr_ack       write accepted this cycle (combinational)
//   wr_addr      RAM write address for this cycle
//   wr_gray      registered Gray write pointer for the read domain
//   full         FIFO full (registered)
//   almost_full  level >= AFULL_THRESH (registered)
//   level        write-side occupancy, 0..2^ADDR_WIDTH (registered)
//   overflow     one-cycle pulse when wr_en arrives while full
module ref_fifo_wr_ptr_ctrl #(
  parameter int ADDR_WIDTH   = 6,
  parameter int AFULL_THRESH = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   rd_gray_sync,
  output logic                  wr_ack,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   wr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow
);

  localparam int P = ADDR_WIDTH + 1;
  localparam logic [P-1:0] AFULL_P = P'(AFULL_THRESH);

  function automatic logic [P-1:0] bin2gray(input logic [P-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [P-1:0] gray2bin(input logic [P-1:0] g);
    logic [P-1:0] b;
    b[P-1] = g[P-1];
    for (int i = P - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [P-1:0] wr_bin_q,   wr_bin_d;
  logic [P-1:0] wr_gray_q,  wr_gray_d;
  logic         full_q,     full_d;
  logic         afull_q,    afull_d;
  logic [P-1:0] level_q,    level_d;
  logic         overflow_q, overflow_d;

  logic         accept;
  logic [P-1:0] rd_bin;
  logic [P-1:0] rd_gray_full;

  // Current-cycle handshake, from registered state only
  assign accept  = wr_en & ~full_q;
  assign wr_ack  = accept;
  assign wr_addr = wr_bin_q[ADDR_WIDTH-1:0];

  // Write pointer one full lap ahead of the read pointer: in Gray code that
  // is the read value with its two top bits inverted.
  assign rd_gray_full = {~rd_gray_sync[P-1:P-2], rd_gray_sync[P-3:0]};
  assign rd_bin       = gray2bin(rd_gray_sync);

  always_comb begin
    wr_bin_d   = wr_bin_q + {{(P-1){1'b0}}, accept};
    wr_gray_d  = bin2gray(wr_bin_d);
    full_d     = (wr_gray_d == rd_gray_full);
    level_d    = wr_bin_d - rd_bin;
    afull_d    = (level_d >= AFULL_P);
    overflow_d = wr_en & full_q;
  end

  // Registered pointer and status
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bin_q   <= '0;
      wr_gray_q  <= '0;
      full_q     <= 1'b0;
      afull_q    <= 1'b0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_bin_q   <= wr_bin_d;
      wr_gray_q  <= wr_gray_d;
      full_q     <= full_d;
      afull_q    <= afull_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  assign wr_gray     = wr_gray_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign level       = level_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_ref_fifo_wr_ptr_ctrl.sv
module tb_ref_fifo_wr_ptr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [3:0] rd_gray_sync;
  logic       wr_ack;
  logic [2:0] wr_addr;
  logic [3:0] wr_gray;
  logic       full;
  logic       almost_full;
  logic [3:0] level;
  logic       overflow;

  int n_total = 0;
  int n_pass  = 0;

  ref_fifo_wr_ptr_ctrl #(
    .ADDR_WIDTH  (3),
    .AFULL_THRESH(6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .rd_gray_sync(rd_gray_sync),
    .wr_ack      (wr_ack),
    .wr_addr     (wr_addr),
    .wr_gray     (wr_gray),
    .full        (full),
    .almost_full (almost_full),
    .level       (level),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] g4(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  // Gray of binary pointer 1..8, hand-computed
  logic [3:0] fill_gray [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                4'b0111, 4'b0101, 4'b0100, 4'b1100};

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_gray_sync = 4'b0101;
    step();
    step();
    // Reset state holds even with a nonzero read pointer present
    chk("rst_gray",  wr_gray, 0);
    chk("rst_level", level, 0);
    chk("rst_full",  full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_ovf",   overflow, 0);

    // Fill from empty, 10 write requests
    rd_gray_sync = 4'b0000;
    rst = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1;
      #1;
      chk($sformatf("fill_ack%0d", i), wr_ack, (i < 8) ? 1 : 0);
      if (i < 8) chk($sformatf("fill_addr%0d", i), wr_addr, i);
      step();
      chk($sformatf("fill_lvl%0d", i),   level, (i < 8) ? i + 1 : 8);
      chk($sformatf("fill_full%0d", i),  full, (i >= 7) ? 1 : 0);
      chk($sformatf("fill_afull%0d", i), almost_full, (i >= 5) ? 1 : 0);
      chk($sformatf("fill_ovf%0d", i),   overflow, (i >= 8) ? 1 : 0);
      chk($sformatf("fill_gray%0d", i),  wr_gray, fill_gray[(i < 8) ? i : 7]);
    end
    wr_en = 1'b0;
    step();
    chk("ovf_clear", overflow, 0);
    chk("full_hold", full, 1);

    // Drain one entry while full
    rd_gray_sync = 4'b0001;
    step();
    chk("drain_full",  full, 0);
    chk("drain_level", level, 7);
    chk("drain_afull", almost_full, 1);
    wr_en = 1'b1;
    #1;
    chk("drain_ack",  wr_ack, 1);
    chk("drain_addr", wr_addr, 0);
    step();
    wr_en = 1'b0;
    chk("refill_full",  full, 1);
    chk("refill_level", level, 8);

    // Wrap-around: alternate one write and one read advance, 16 times
    rst = 1'b1;
    step();
    rst = 1'b0; rd_gray_sync = 4'b0000;
    step();
    for (int k = 1; k <= 16; k++) begin
      wr_en = 1'b1;
      step();
      wr_en = 1'b0;
      chk($sformatf("wrap_wlvl%0d", k),  level, 1);
      chk($sformatf("wrap_full%0d", k),  full, 0);
      chk($sformatf("wrap_gray%0d", k),  wr_gray, g4(k));
      if (k == 15) chk("wrap_gray_1000", wr_gray, 4'b1000);
      if (k == 16) chk("wrap_gray_0000", wr_gray, 4'b0000);
      rd_gray_sync = g4(k);
      step();
      chk($sformatf("wrap_rlvl%0d", k), level, 0);
    end

    // Simultaneous write and read advance at level 5
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1;
      step();
    end
    chk("sim_pre_lvl",   level, 5);
    chk("sim_pre_afull", almost_full, 0);
    rd_gray_sync = 4'b0001;
    #1;
    chk("sim_ack", wr_ack, 1);
    step();
    wr_en = 1'b0;
    chk("sim_lvl",   level, 5);
    chk("sim_afull", almost_full, 0);
    chk("sim_gray",  wr_gray, 4'b0101);

    // Reset in the middle of a fill
    rst = 1'b1;
    step();
    rst = 1'b0; rd_gray_sync = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1;
      step();
    end
    chk("mid_lvl4", level, 4);
    rst = 1'b1;
    #1;
    chk("mid_rst_ack1", wr_ack, 1);
    step();
    chk("mid_rst_gray", wr_gray, 0);
    chk("mid_rst_lvl",  level, 0);
    chk("mid_rst_full", full, 0);
    wr_en = 1'b0;
    #1;
    chk("mid_rst_ack0", wr_ack, 0);
    step();
    rst = 1'b0; wr_en = 1'b1;
    #1;
    chk("post_rst_addr", wr_addr, 0);
    chk("post_rst_ack",  wr_ack, 1);
    step();
    wr_en = 1'b0;
    chk("post_rst_lvl", level, 1);
    chk("post_rst_gray", wr_gray, 4'b0001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
